// File: rtl/router_port_sched.sv
// router_port_sched: four-input round-robin scheduler feeding per-target output FIFOs.
// Each granted packet gets one push strobe, then one pop strobe back to the granted input.
// If its target id is out of range, the packet is dropped instead: one pop plus an err pulse.
// All outputs are registered.
// Optional build macro ROUTER_PORT_SCHED_GRANT_CNT_EN adds output grant_cnt,
// which holds one 16-bit completed-grant counter per input port.
module router_port_sched #(
   parameter int pckg_sz = 40
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           pndng_i,
   input  logic [4*pckg_sz-1:0] data_out_i,
   input  logic [3:0]           full_i,
   output logic [1:0]           trn,
   output logic                 push_i,
   output logic                 pop_i,
   output logic [pckg_sz-1:0]   data_in_i,
   output logic                 busy,
   output logic                 err
`ifdef ROUTER_PORT_SCHED_GRANT_CNT_EN
   ,
   output logic [4*16-1:0]      grant_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH,
      S_POP,
      S_WAIT,
      S_DROP
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [1:0]           r_rr_ptr;
   logic                 w_found;
   logic [1:0]           w_win;
   logic [pckg_sz-1:0]   w_win_pkt;
   logic [7:0]           w_win_tgt;
   logic [1:0]           w_cur_sel;

   assign w_win_pkt = data_out_i[int'(w_win)*pckg_sz +: pckg_sz];
   assign w_win_tgt = w_win_pkt[pckg_sz-1 -: 8];
   assign w_cur_sel = data_in_i[pckg_sz-8 +: 2];

   // Round-robin search: first pending port at or after r_rr_ptr wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_rr_ptr;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!w_found && pndng_i[r_rr_ptr + 2'(i)]) begin
            w_found = 1'b1;
            w_win   = r_rr_ptr + 2'(i);
         end
      end
   end

   // Next-state logic; grant routing decided from the winner's target id.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               if (|w_win_tgt[7:2])
                  w_next = S_DROP;
               else if (full_i[w_win_tgt[1:0]])
                  w_next = S_WAIT;
               else
                  w_next = S_PUSH;
            end
         end
         S_PUSH:  w_next = S_POP;
         S_POP:   w_next = S_IDLE;
         S_WAIT:  if (!full_i[w_cur_sel]) w_next = S_PUSH;
         S_DROP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Registered outputs decoded from the upcoming state, so strobes coincide with PUSH/POP/DROP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr  <= '0;
         trn       <= '0;
         data_in_i <= '0;
         push_i    <= 1'b0;
         pop_i     <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         push_i <= (w_next == S_PUSH);
         pop_i  <= (w_next == S_POP) || (w_next == S_DROP);
         err    <= (w_next == S_DROP);
         busy   <= (w_next != S_IDLE);
         if (r_state == S_IDLE && w_found) begin
            trn       <= w_win;
            data_in_i <= w_win_pkt;
         end
         if (r_state == S_POP || r_state == S_DROP)
            r_rr_ptr <= trn + 2'd1;
      end
   end

`ifdef ROUTER_PORT_SCHED_GRANT_CNT_EN
   logic [15:0] r_grant_cnt [4];

   // Count each completed grant (popped or dropped) against its input port.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 4; i++)
            r_grant_cnt[i] <= '0;
      end else if (r_state == S_POP || r_state == S_DROP) begin
         r_grant_cnt[trn] <= r_grant_cnt[trn] + 16'd1;
      end
   end

   // Flatten the counters onto the output bus, port p at bits [p*16 +: 16].
   always_comb begin
      grant_cnt = '0;
      for (int unsigned i = 0; i < 4; i++)
         grant_cnt[i*16 +: 16] = r_grant_cnt[i];
   end
`endif

endmodule

// File: tb/tb_router_port_sched.sv
// Self-checking bench for router_port_sched: expected grants are queued when stimulus
// is driven and checked when the DUT raises push_i.
module tb_router_port_sched;
   localparam int PW = 40;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      pndng_i;
   logic [4*PW-1:0] data_out_i;
   logic [3:0]      full_i;
   logic [1:0]      trn;
   logic            push_i;
   logic            pop_i;
   logic [PW-1:0]   data_in_i;
   logic            busy;
   logic            err;
`ifdef ROUTER_PORT_SCHED_GRANT_CNT_EN
   logic [63:0]     grant_cnt;
`endif

   always #5 clk = ~clk;

   router_port_sched #(.pckg_sz(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .pndng_i    (pndng_i),
      .data_out_i (data_out_i),
      .full_i     (full_i),
      .trn        (trn),
      .push_i     (push_i),
      .pop_i      (pop_i),
      .data_in_i  (data_in_i),
      .busy       (busy),
      .err        (err)
`ifdef ROUTER_PORT_SCHED_GRANT_CNT_EN
      ,
      .grant_cnt  (grant_cnt)
`endif
   );

   typedef struct packed {
      logic [1:0]    trn;
      logic [PW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic logic [PW-1:0] mk(input logic [7:0] tgt, input logic [31:0] pl);
      return {tgt, pl};
   endfunction

   task automatic set_port(input int p, input logic [PW-1:0] pk);
      data_out_i[p*PW +: PW] = pk;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 20 && busy; n++) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b want 0", busy); else n_pass++;
   endtask

   task automatic test_reset();
      exp_t z;
      rst = 1'b1; pndng_i = 4'b0001; full_i = '0; data_out_i = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (trn !== 2'd0) $display("FAIL rst_trn: got %0d want 0", trn); else n_pass++;
      n_checks++; if (push_i !== 1'b0) $display("FAIL rst_push: got %b want 0", push_i); else n_pass++;
      n_checks++; if (pop_i !== 1'b0) $display("FAIL rst_pop: got %b want 0", pop_i); else n_pass++;
      n_checks++; if (data_in_i !== '0) $display("FAIL rst_data: got %h want 0", data_in_i); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
      z = '0;
      rst = 1'b0; pndng_i = '0;
      if (z.trn != 2'd0) $display("note");
   endtask

   task automatic test_basic();
      exp_t e;
      logic [PW-1:0] pk;
      pk = mk(8'd1, 32'hA5A5_0002);
      set_port(0, mk(8'd0, 32'h1111_0000));
      set_port(1, mk(8'd0, 32'h1111_0001));
      set_port(2, pk);
      set_port(3, mk(8'd0, 32'h1111_0003));
      sb.push_back('{trn: 2'd2, data: pk});
      pndng_i = 4'b0100;
      @(negedge clk);
      pndng_i = '0;
      n_checks++; if (push_i !== 1'b1) $display("FAIL basic_push: got %b want 1", push_i); else n_pass++;
      n_checks++; if (pop_i !== 1'b0) $display("FAIL basic_nopop: got %b want 0", pop_i); else n_pass++;
      e = sb.pop_front();
      n_checks++; if (trn !== e.trn) $display("FAIL basic_trn: got %0d want %0d", trn, e.trn); else n_pass++;
      n_checks++; if (data_in_i !== e.data) $display("FAIL basic_data: got %h want %h", data_in_i, e.data); else n_pass++;
      @(negedge clk);
      n_checks++; if ({push_i, pop_i} !== 2'b01) $display("FAIL basic_pop: push/pop=%b want 01", {push_i, pop_i}); else n_pass++;
      n_checks++; if (trn !== 2'd2) $display("FAIL basic_pop_trn: got %0d want 2", trn); else n_pass++;
      @(negedge clk);
      n_checks++; if ({busy, pop_i} !== 2'b00) $display("FAIL basic_idle: busy/pop=%b want 00", {busy, pop_i}); else n_pass++;
   endtask

   task automatic test_rotation();
      exp_t e;
      logic [PW-1:0] pk [4];
      int pushes = 0, last = -1, cyc = 0, bad_gap = 0, overlap = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int p = 0; p < 4; p++) begin
         pk[p] = mk(8'd0, 32'hC0DE_0000 | p);
         set_port(p, pk[p]);
      end
      for (int k = 0; k < 8; k++) sb.push_back('{trn: 2'(k % 4), data: pk[k % 4]});
      pndng_i = 4'b1111;
      while (pushes < 8 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (push_i && pop_i) overlap++;
         if (push_i === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; if (trn !== e.trn) $display("FAIL rot_trn%0d: got %0d want %0d", pushes, trn, e.trn); else n_pass++;
            n_checks++; if (data_in_i !== e.data) $display("FAIL rot_data%0d: got %h want %h", pushes, data_in_i, e.data); else n_pass++;
            if (last >= 0 && cyc - last != 3) bad_gap++;
            last = cyc;
            pushes++;
            if (pushes == 8) pndng_i = '0;
         end
      end
      pndng_i = '0;
      n_checks++; if (pushes !== 8) $display("FAIL rot_count: got %0d pushes want 8", pushes); else n_pass++;
      n_checks++; if (bad_gap !== 0) $display("FAIL rot_gap: got %0d gaps not 3 cycles want 0", bad_gap); else n_pass++;
      n_checks++; if (overlap !== 0) $display("FAIL rot_overlap: got %0d push+pop cycles want 0", overlap); else n_pass++;
      wait_idle();
   endtask

   task automatic test_wait();
      exp_t e;
      logic [PW-1:0] pk;
      int viol = 0;
      pk = mk(8'd3, 32'h3333_0000);
      set_port(0, pk);
      sb.push_back('{trn: 2'd0, data: pk});
      full_i  = 4'b1000;
      pndng_i = 4'b0001;
      @(negedge clk);
      pndng_i = '0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         if (busy !== 1'b1 || push_i !== 1'b0 || pop_i !== 1'b0) viol++;
      end
      full_i = '0;
      n_checks++; if (viol !== 0) $display("FAIL wait_hold: got %0d bad cycles want 0", viol); else n_pass++;
      @(negedge clk);
      n_checks++; if (push_i !== 1'b1) $display("FAIL wait_push: got %b want 1", push_i); else n_pass++;
      e = sb.pop_front();
      n_checks++; if ({trn, data_in_i} !== {e.trn, e.data}) $display("FAIL wait_grant: got %0d/%h want %0d/%h", trn, data_in_i, e.trn, e.data); else n_pass++;
      @(negedge clk);
      n_checks++; if ({push_i, pop_i} !== 2'b01) $display("FAIL wait_pop: push/pop=%b want 01", {push_i, pop_i}); else n_pass++;
      wait_idle();
   endtask

   task automatic test_drop();
      exp_t e;
      logic [PW-1:0] pk2;
      pk2 = mk(8'd0, 32'h2222_0002);
      set_port(0, mk(8'd0, 32'h2222_0000));
      set_port(1, mk(8'h07, 32'hDEAD_0001));
      set_port(2, pk2);
      set_port(3, mk(8'd0, 32'h2222_0003));
      pndng_i = 4'b0010;
      @(negedge clk);
      pndng_i = '0;
      n_checks++; if ({err, pop_i, push_i} !== 3'b110) $display("FAIL drop_strobe: err/pop/push=%b want 110", {err, pop_i, push_i}); else n_pass++;
      n_checks++; if (trn !== 2'd1) $display("FAIL drop_trn: got %0d want 1", trn); else n_pass++;
      @(negedge clk);
      n_checks++; if ({err, pop_i, push_i, busy} !== 4'b0000) $display("FAIL drop_end: err/pop/push/busy=%b want 0000", {err, pop_i, push_i, busy}); else n_pass++;
      sb.push_back('{trn: 2'd2, data: pk2});
      pndng_i = 4'b1111;
      @(negedge clk);
      pndng_i = '0;
      e = sb.pop_front();
      n_checks++; if (push_i !== 1'b1) $display("FAIL drop_next_push: got %b want 1", push_i); else n_pass++;
      n_checks++; if ({trn, data_in_i} !== {e.trn, e.data}) $display("FAIL drop_next_grant: got %0d/%h want %0d/%h", trn, data_in_i, e.trn, e.data); else n_pass++;
      wait_idle();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      logic [PW-1:0] pk0;
      set_port(0, mk(8'd2, 32'h4444_0000));
      pndng_i = 4'b0001;
      @(negedge clk);
      pndng_i = '0;
      n_checks++; if (push_i !== 1'b1) $display("FAIL rmid_push: got %b want 1", push_i); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if ({trn, push_i, pop_i, data_in_i, busy, err} !== '0) $display("FAIL rmid_clear: got trn=%0d push=%b pop=%b data=%h busy=%b err=%b want all 0", trn, push_i, pop_i, data_in_i, busy, err); else n_pass++;
      rst = 1'b0;
      pk0 = mk(8'd1, 32'h5555_0000);
      for (int p = 0; p < 4; p++) set_port(p, mk(8'd1, 32'h5555_0000 | p));
      sb.push_back('{trn: 2'd0, data: pk0});
      pndng_i = 4'b1111;
      @(negedge clk);
      pndng_i = '0;
      e = sb.pop_front();
      n_checks++; if (push_i !== 1'b1) $display("FAIL rmid_regrant_push: got %b want 1", push_i); else n_pass++;
      n_checks++; if ({trn, data_in_i} !== {e.trn, e.data}) $display("FAIL rmid_regrant: got %0d/%h want %0d/%h", trn, data_in_i, e.trn, e.data); else n_pass++;
      wait_idle();
   endtask

`ifdef ROUTER_PORT_SCHED_GRANT_CNT_EN
   task automatic test_grant_cnt();
      int pushes = 0, cyc = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (grant_cnt !== 64'd0) $display("FAIL cnt_reset: got %h want 0", grant_cnt); else n_pass++;
      set_port(3, mk(8'd1, 32'h6666_0003));
      pndng_i = 4'b1000;
      while (pushes < 3 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (push_i === 1'b1) begin
            pushes++;
            if (pushes == 3) pndng_i = '0;
         end
      end
      pndng_i = '0;
      wait_idle();
      set_port(0, mk(8'hFF, 32'h6666_0000));
      pndng_i = 4'b0001;
      @(negedge clk);
      pndng_i = '0;
      wait_idle();
      n_checks++; if (grant_cnt !== {16'd3, 16'd0, 16'd0, 16'd1}) $display("FAIL cnt_value: got %h want %h", grant_cnt, {16'd3, 16'd0, 16'd0, 16'd1}); else n_pass++;
   endtask
`endif

   initial begin
      rst = 1'b1; pndng_i = '0; full_i = '0; data_out_i = '0;
      test_reset();
      test_basic();
      test_rotation();
      test_wait();
      test_drop();
      test_reset_mid();
`ifdef ROUTER_PORT_SCHED_GRANT_CNT_EN
      test_grant_cnt();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/router_port_sched.md
ROUTER_PORT_SCHED -- requirements
Module: router_port_sched

Interface
REQ-001 Parameter: pckg_sz, default 40, packet width in bits; bits [pckg_sz-1:pckg_sz-8] carry the target port id.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: pndng_i  input  4  per-input-port "packet pending" flag.
REQ-005 Port: data_out_i  input  4*pckg_sz  head packets; port p occupies bits [p*pckg_sz +: pckg_sz].
REQ-006 Port: full_i  input  4  per-output-FIFO full flag.
REQ-007 Port: trn  output  2  index of the granted input port.
REQ-008 Port: push_i  output  1  one-cycle push strobe to output FIFO selected by data_in_i target id.
REQ-009 Port: pop_i  output  1  one-cycle pop strobe to input port trn.
REQ-010 Port: data_in_i  output  pckg_sz  latched packet of the granted port.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.
REQ-012 Port: err  output  1  one-cycle pulse when a packet with an invalid target is dropped.

Function
REQ-013 FSM states: IDLE, PUSH, POP, WAIT, DROP; all outputs SHALL be registered.
REQ-014 IDLE: scan pndng_i round-robin starting at rr_ptr; first set bit wins; if none, stay IDLE.
REQ-015 On a grant in IDLE, trn and data_in_i SHALL load the winner index and packet in the same edge.
REQ-016 Next state from IDLE: DROP if target id > 3; WAIT if full_i[target]; otherwise PUSH.
REQ-017 PUSH: push_i=1 for exactly one cycle, then POP.
REQ-018 POP: pop_i=1 for exactly one cycle with trn unchanged; rr_ptr SHALL become (trn+1) mod 4; next IDLE.
REQ-019 WAIT: no strobes; move to PUSH on the first cycle full_i[target] is low; no timeout.
REQ-020 DROP: pop_i=1 and err=1 for one cycle, push_i stays 0; rr_ptr advances as in POP; next IDLE.
REQ-021 Latency: pndng sampled in IDLE at edge N -> push_i high cycle N+1, pop_i high cycle N+2, IDLE at N+3; minimum 3 cycles per packet.
REQ-022 After a grant, pndng_i and data_out_i of the granted port SHALL be ignored until return to IDLE.
REQ-023 push_i and pop_i SHALL never be high in the same cycle.
REQ-024 rr_ptr wraps 3 -> 0; with all four ports pending continuously, grants SHALL rotate 0,1,2,3,0.
REQ-025 A port that becomes pending during a transaction SHALL be considered at the next IDLE cycle only.

Reset
REQ-026 While rst is high at a clock edge: state=IDLE, rr_ptr=0, trn=0, data_in_i=0, push_i=0, pop_i=0, busy=0, err=0.
REQ-027 Reset mid-transaction SHALL abandon the grant with no further strobes; a packet already pushed but not popped is not replayed.
REQ-028 First grant after reset release SHALL occur at the first edge with rst low and any pndng_i set.

Configuration
REQ-029 Macro ROUTER_PORT_SCHED_GRANT_CNT_EN: when defined, adds output grant_cnt (4*16 bits) with one 16-bit counter per input port.
REQ-030 Each counter SHALL increment on POP or DROP for port trn, wrap 0xFFFF -> 0, and clear on rst.
REQ-031 When the macro is undefined, grant_cnt and the counters SHALL not exist; all other behaviour is identical.

Verification
REQ-032 Scenario: pndng_i=4'b0100, port2 target 1, full_i=0 -> trn=2, push_i cycle N+1, pop_i N+2, data_in_i = port2 packet.
REQ-033 Scenario: pndng_i=4'b1111 held, all targets 0, for 8 packets -> trn sequence 0,1,2,3,0,1,2,3.
REQ-034 Scenario: port0 target 3, full_i[3]=1 for 5 cycles -> busy=1, no strobes during WAIT, push_i one cycle after full_i[3] falls.
REQ-035 Scenario: port1 target id 8'h07 -> err=1 and pop_i=1 in the same cycle, push_i never set, next grant starts at port2.
REQ-036 Scenario: rst asserted the cycle push_i is high -> next cycle all outputs 0, state IDLE, rr_ptr=0.
REQ-037 Scenario (macro defined): 3 packets from port 3 and 1 dropped from port 0 -> grant_cnt port3=3, port0=1, others 0.
